// File: rtl/program_loader.sv
// -----------------------------------------------------------------------------
// program_loader
//   Writer side of the instruction-memory interface. Assembles a received
//   byte stream (MSB byte first) into BITS-wide instruction words and writes
//   them to consecutive program-memory addresses starting at 0. The CPU is
//   held in reset (o_cpu_rst=0) until the load session completes, either on
//   a halt word (all zero) or when the address space runs out (o_full).
//
//   Optional build macro PROGRAM_LOADER_CHECKSUM_EN: after the halt word a
//   trailing checksum byte (XOR of every data byte in the session) is
//   expected; a mismatch raises o_csum_err and keeps the CPU in reset.
//
// Ports
//   i_clk, i_rst        clock (rising edge), async active-low reset
//   i_start             one-cycle pulse, starts a session from IDLE/DONE
//   i_rx_data/_valid    received byte and its one-cycle strobe
//   o_wr_en/addr/data   program-memory write port (one strobe per word)
//   o_busy, o_done      session in progress / finished (level)
//   o_full              session ended by address exhaustion
//   o_csum_err          checksum mismatch (checksum build only)
//   o_cpu_rst           active-low CPU reset
// -----------------------------------------------------------------------------
module program_loader #(
  parameter int BITS   = 16,
  parameter int DTBITS = BITS - 5,
  parameter int NBYTES = BITS / 8
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic [7:0]        i_rx_data,
  input  logic              i_rx_valid,
  output logic              o_wr_en,
  output logic [DTBITS-1:0] o_wr_addr,
  output logic [BITS-1:0]   o_wr_data,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_full,
`ifdef PROGRAM_LOADER_CHECKSUM_EN
  output logic              o_csum_err,
`endif
  output logic              o_cpu_rst
);

  localparam int CW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [CW-1:0] LAST_BYTE = CW'(NBYTES - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_RECV  = 3'd1;
  localparam logic [2:0] S_WRITE = 3'd2;
  localparam logic [2:0] S_DONE  = 3'd3;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
  localparam logic [2:0] S_CHECK = 3'd4;
`endif

  logic [2:0]        state_q, state_d;
  logic [DTBITS-1:0] addr_q, addr_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [BITS-1:0]   word_q, word_d;
  logic              wr_en_q, wr_en_d;
  logic [DTBITS-1:0] wr_addr_q, wr_addr_d;
  logic [BITS-1:0]   wr_data_q, wr_data_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              full_q, full_d;
  logic              cpu_rst_q, cpu_rst_d;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
  logic [7:0]        csum_q, csum_d;
  logic              csum_err_q, csum_err_d;
`endif
  logic              take;   // shift i_rx_data into the word this cycle

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    cnt_d     = cnt_q;
    word_d    = word_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    busy_d    = busy_q;
    done_d    = done_q;
    full_d    = full_q;
    cpu_rst_d = cpu_rst_q;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    csum_d     = csum_q;
    csum_err_d = csum_err_q;
`endif
    take      = 1'b0;

    case (state_q)
      S_IDLE, S_DONE: begin
        // i_rx_valid is ignored here; only i_start matters.
        if (i_start) begin
          state_d   = S_RECV;
          addr_d    = '0;
          cnt_d     = '0;
          busy_d    = 1'b1;
          done_d    = 1'b0;
          full_d    = 1'b0;
          cpu_rst_d = 1'b0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
          csum_d     = '0;
          csum_err_d = 1'b0;
`endif
        end
      end
      S_RECV: take = i_rx_valid;
      S_WRITE: begin
        // wr_data_q still holds the word being written; word_q may already
        // be taking the next word's first byte.
        if (wr_data_q == '0) begin
`ifdef PROGRAM_LOADER_CHECKSUM_EN
          if (i_rx_valid) begin
            // checksum byte arrived back-to-back with the halt write
            state_d    = S_DONE;
            busy_d     = 1'b0;
            done_d     = 1'b1;
            csum_err_d = (i_rx_data != csum_q);
            cpu_rst_d  = (i_rx_data == csum_q);
          end else begin
            state_d = S_CHECK;
          end
`else
          state_d   = S_DONE;
          busy_d    = 1'b0;
          done_d    = 1'b1;
          cpu_rst_d = 1'b1;
`endif
        end else if (addr_q == '1) begin
          // no room for another word: stop rather than wrap
          state_d   = S_DONE;
          busy_d    = 1'b0;
          done_d    = 1'b1;
          full_d    = 1'b1;
          cpu_rst_d = 1'b1;
        end else begin
          state_d = S_RECV;
          addr_d  = addr_q + DTBITS'(1);
          take    = i_rx_valid;
        end
      end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      S_CHECK: begin
        if (i_rx_valid) begin
          state_d    = S_DONE;
          busy_d     = 1'b0;
          done_d     = 1'b1;
          csum_err_d = (i_rx_data != csum_q);
          cpu_rst_d  = (i_rx_data == csum_q);
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase

    if (take) begin
      word_d = (word_q << 8) | BITS'(i_rx_data);
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      csum_d = csum_d ^ i_rx_data;
`endif
      if (cnt_q == LAST_BYTE) begin
        cnt_d     = '0;
        state_d   = S_WRITE;
        wr_en_d   = 1'b1;
        wr_addr_d = addr_d;
        wr_data_d = word_d;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      cnt_q      <= '0;
      word_q     <= '0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      full_q     <= 1'b0;
      cpu_rst_q  <= 1'b0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      csum_q     <= '0;
      csum_err_q <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      cnt_q      <= cnt_d;
      word_q     <= word_d;
      wr_en_q    <= wr_en_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      full_q     <= full_d;
      cpu_rst_q  <= cpu_rst_d;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      csum_q     <= csum_d;
      csum_err_q <= csum_err_d;
`endif
    end
  end

  assign o_wr_en   = wr_en_q;
  assign o_wr_addr = wr_addr_q;
  assign o_wr_data = wr_data_q;
  assign o_busy    = busy_q;
  assign o_done    = done_q;
  assign o_full    = full_q;
  assign o_cpu_rst = cpu_rst_q;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
  assign o_csum_err = csum_err_q;
`endif

endmodule

// File: tb/tb_program_loader.sv
// -----------------------------------------------------------------------------
// tb_program_loader
//   Directed bench for program_loader. Two instances share the stimulus: the
//   default geometry (DTBITS=11) and a DTBITS=3 copy that runs out of address
//   space after eight words. Expected writes are queued when a word is sent
//   and popped by a monitor when o_wr_en is seen.
// -----------------------------------------------------------------------------
module tb_program_loader;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       rx_valid = 1'b0;
  logic [7:0] rx_data = 8'h00;

  always #5 clk = ~clk;

  logic        wr_en, busy, done, full, cpu_rst;
  logic [10:0] wr_addr;
  logic [15:0] wr_data;
  logic        s_wr_en, s_busy, s_done, s_full, s_cpu_rst;
  logic [2:0]  s_wr_addr;
  logic [15:0] s_wr_data;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
  logic        csum_err, s_csum_err;
`endif

  program_loader dut (
    .i_clk(clk), .i_rst(rst_n), .i_start(start),
    .i_rx_data(rx_data), .i_rx_valid(rx_valid),
    .o_wr_en(wr_en), .o_wr_addr(wr_addr), .o_wr_data(wr_data),
    .o_busy(busy), .o_done(done), .o_full(full),
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    .o_csum_err(csum_err),
`endif
    .o_cpu_rst(cpu_rst)
  );

  program_loader #(.BITS(16), .DTBITS(3)) dut_s (
    .i_clk(clk), .i_rst(rst_n), .i_start(start),
    .i_rx_data(rx_data), .i_rx_valid(rx_valid),
    .o_wr_en(s_wr_en), .o_wr_addr(s_wr_addr), .o_wr_data(s_wr_data),
    .o_busy(s_busy), .o_done(s_done), .o_full(s_full),
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    .o_csum_err(s_csum_err),
`endif
    .o_cpu_rst(s_cpu_rst)
  );

  typedef struct packed {
    logic [15:0] a;
    logic [15:0] d;
  } wr_t;

  wr_t qb[$];
  wr_t qs[$];
  int  n_vec = 0;
  int  n_err = 0;
  logic [7:0] sess_x = 8'h00;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // write scoreboards
  wr_t eb, es;
  always @(negedge clk) begin
    if (wr_en === 1'b1) begin
      chk("big_wr_expected", 32'(qb.size() != 0), 1);
      if (qb.size() != 0) begin
        eb = qb.pop_front();
        chk("big_wr_addr", 32'(wr_addr), 32'(eb.a));
        chk("big_wr_data", 32'(wr_data), 32'(eb.d));
      end
    end
    if (s_wr_en === 1'b1) begin
      chk("small_wr_expected", 32'(qs.size() != 0), 1);
      if (qs.size() != 0) begin
        es = qs.pop_front();
        chk("small_wr_addr", 32'(s_wr_addr), 32'(es.a));
        chk("small_wr_data", 32'(s_wr_data), 32'(es.d));
      end
    end
  end

  task automatic exp_both(input int a, input logic [15:0] d);
    qb.push_back(wr_t'{16'(a), d});
    qs.push_back(wr_t'{16'(a), d});
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    tick(gap);
    rx_data  = b;
    rx_valid = 1'b1;
    sess_x   = sess_x ^ b;
    tick(1);
    rx_valid = 1'b0;
  endtask

  task automatic pulse_start();
    start  = 1'b1;
    sess_x = 8'h00;
    tick(1);
    start  = 1'b0;
  endtask

  task automatic end_session();
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    send_byte(sess_x, 0);
`endif
  endtask

  task automatic wait_done(input string tag);
    int i;
    for (i = 0; i < 20; i++) begin
      if (done === 1'b1) break;
      tick(1);
    end
    chk(tag, 32'(done), 1);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    logic [15:0] w;

    // ---- reset state
    tick(2);
    chk("rst_wr_en", 32'(wr_en), 0);
    chk("rst_wr_addr", 32'(wr_addr), 0);
    chk("rst_wr_data", 32'(wr_data), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_full", 32'(full), 0);
    chk("rst_cpu_rst", 32'(cpu_rst), 0);
    rst_n = 1'b1;
    tick(1);

    // ---- basic load: 0x0805 then halt
    pulse_start();
    chk("t1_busy", 32'(busy), 1);
    chk("t1_cpu_rst_held", 32'(cpu_rst), 0);
    exp_both(0, 16'h0805);
    exp_both(1, 16'h0000);
    send_byte(8'h08, 0);
    send_byte(8'h05, 0);
    chk("t1_wr_latency", 32'(wr_en), 1);
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
    end_session();
    wait_done("t1_done");
    tick(1);
    chk("t1_cpu_rst", 32'(cpu_rst), 1);
    chk("t1_full", 32'(full), 0);
    chk("t1_busy_end", 32'(busy), 0);
    chk("t1_pending", 32'(qb.size() + qs.size()), 0);

    // ---- gaps, byte in WRITE cycle, i_start during RECV
    pulse_start();
    chk("t2_done_cleared", 32'(done), 0);
    chk("t2_busy", 32'(busy), 1);
    chk("t2_cpu_rst", 32'(cpu_rst), 0);
    exp_both(0, 16'h1234);
    exp_both(1, 16'hABCD);
    exp_both(2, 16'h0000);
    send_byte(8'h12, 0);
    start = 1'b1;                       // must be ignored while busy
    tick(1);
    start = 1'b0;
    chk("t2_start_ignored", 32'(busy), 1);
    send_byte(8'h34, 3);
    chk("t2_wr_en", 32'(wr_en), 1);
    send_byte(8'hAB, 0);                // strobed during the WRITE cycle
    send_byte(8'hCD, 7);
    send_byte(8'h00, 2);
    send_byte(8'h00, 5);
    end_session();
    wait_done("t2_done");
    // strobes in DONE must not write
    send_byte(8'h55, 1);
    send_byte(8'h55, 1);
    tick(3);
    chk("t2_done_hold", 32'(done), 1);
    chk("t2_busy_end", 32'(busy), 0);
    chk("t2_pending", 32'(qb.size() + qs.size()), 0);

    // ---- address exhaustion on the DTBITS=3 instance
    pulse_start();
    chk("t3_done_cleared", 32'(done), 0);
    for (int i = 0; i < 8; i++) begin
      w = 16'h1111 * 16'(i + 1);
      exp_both(i, w);
      send_byte(w[15:8], i % 3);
      send_byte(w[7:0], 0);
    end
    tick(2);
    chk("t3_s_done", 32'(s_done), 1);
    chk("t3_s_full", 32'(s_full), 1);
    chk("t3_s_cpu_rst", 32'(s_cpu_rst), 1);
    chk("t3_s_busy", 32'(s_busy), 0);
    chk("t3_big_busy", 32'(busy), 1);
    qb.push_back(wr_t'{16'd8, 16'h0000});
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
    end_session();
    wait_done("t3_big_done");
    chk("t3_big_full", 32'(full), 0);
    chk("t3_pending", 32'(qb.size() + qs.size()), 0);

    // ---- async reset mid-word
    pulse_start();
    send_byte(8'h77, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("t4_busy", 32'(busy), 0);
    chk("t4_cpu_rst", 32'(cpu_rst), 0);
    chk("t4_wr_addr", 32'(wr_addr), 0);
    chk("t4_wr_data", 32'(wr_data), 0);
    chk("t4_s_full", 32'(s_full), 0);
    chk("t4_done", 32'(done), 0);
    tick(2);
    rst_n = 1'b1;
    send_byte(8'h88, 0);                // IDLE: ignored
    tick(2);
    chk("t4_idle_busy", 32'(busy), 0);
    chk("t4_idle_cpu_rst", 32'(cpu_rst), 0);
    pulse_start();
    exp_both(0, 16'h0102);
    exp_both(1, 16'h0000);
    send_byte(8'h01, 0);
    send_byte(8'h02, 1);
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
    end_session();
    wait_done("t4_done");
    tick(1);
    chk("t4_cpu_rst_end", 32'(cpu_rst), 1);
    chk("t4_pending", 32'(qb.size() + qs.size()), 0);

`ifdef PROGRAM_LOADER_CHECKSUM_EN
    // ---- checksum good / bad
    pulse_start();
    exp_both(0, 16'h0805);
    exp_both(1, 16'h0000);
    send_byte(8'h08, 0);
    send_byte(8'h05, 0);
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
    tick(2);
    chk("t5_wait_check", 32'(done), 0);
    send_byte(8'h0D, 0);
    chk("t5_done", 32'(done), 1);
    chk("t5_csum_ok", 32'(csum_err), 0);
    chk("t5_cpu_rst", 32'(cpu_rst), 1);
    pulse_start();
    exp_both(0, 16'h0805);
    exp_both(1, 16'h0000);
    send_byte(8'h08, 0);
    send_byte(8'h05, 0);
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
    send_byte(8'h0C, 2);
    chk("t5b_done", 32'(done), 1);
    chk("t5b_csum_err", 32'(csum_err), 1);
    chk("t5b_cpu_rst", 32'(cpu_rst), 0);
    pulse_start();
    chk("t5c_csum_cleared", 32'(csum_err), 0);
    chk("t5_pending", 32'(qb.size() + qs.size()), 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/program_loader.md
Name: program_loader

Overview:
- Writer side of the instruction-memory interface: fills program memory that the CPU control unit later reads through its PC-driven address.
- Receives a byte stream from a serial receiver and assembles BITS-wide instruction words, MSB byte first.
- Writes each word to consecutive program-memory addresses starting at 0.
- Holds the CPU in reset until the program has been loaded.

Parameters:
- BITS, 16, instruction word width; must be a multiple of 8.
- DTBITS, BITS-5, program-memory address width (operand field width).
- NBYTES, BITS/8, bytes per instruction word.

Ports:
- i_clk  input  1  system clock, rising edge
- i_rst  input  1  asynchronous, active-low reset
- i_start  input  1  one-cycle pulse that begins a load session
- i_rx_data  input  8  received byte
- i_rx_valid  input  1  one-cycle strobe; i_rx_data is valid in that cycle
- o_wr_en  output  1  program-memory write strobe, one cycle per word
- o_wr_addr  output  DTBITS  program-memory write address
- o_wr_data  output  BITS  program-memory write data
- o_busy  output  1  load session in progress
- o_done  output  1  load finished; level signal, held until next i_start
- o_full  output  1  load ended because the address space was exhausted before a halt word arrived
- o_cpu_rst  output  1  active-low reset to the CPU; 0 holds the CPU in reset

Behaviour:
- Reset (i_rst=0, asynchronous):
  - State IDLE; address register, byte counter and assembly register cleared.
  - o_wr_en, o_busy, o_done, o_full = 0; o_cpu_rst = 0 (CPU held in reset).
  - o_wr_addr and o_wr_data = 0.
- States: IDLE, RECV, WRITE, DONE.
- IDLE:
  - i_start=1 -> RECV next cycle.
  - On entry to RECV: address=0, byte count=0, o_busy=1, o_cpu_rst=0.
  - i_rx_valid is ignored in IDLE.
- RECV:
  - Each i_rx_valid shifts i_rx_data into the assembly register: word = {word[BITS-9:0], byte}, and increments the byte count.
  - When the strobe carries byte number NBYTES-1 -> WRITE next cycle; byte count resets to 0.
- WRITE (exactly one cycle):
  - o_wr_en=1; o_wr_addr = address register; o_wr_data = assembled word.
  - Latency: write strobe is asserted the cycle after the last byte's i_rx_valid.
  - Exit:
    - Word == 0 (halt instruction, opcode 0 / operand 0) -> DONE.
    - Otherwise, address == 2^DTBITS-1 -> DONE with o_full=1.
    - Otherwise address increments and the state returns to RECV.
  - An i_rx_valid arriving during WRITE is accepted as byte 0 of the next word; no byte is dropped.
  - If WRITE exits to DONE, that byte is discarded.
- DONE:
  - o_busy=0, o_done=1, o_cpu_rst=1 (CPU released); o_wr_en=0.
  - o_full keeps its value.
  - i_start -> RECV: clears o_done and o_full, sets o_cpu_rst=0, address=0.
- i_start while o_busy=1 is ignored.
- o_wr_addr and o_wr_data hold their last values outside WRITE; only o_wr_en qualifies them.
- Address arithmetic is unsigned, DTBITS wide, and never wraps; the full condition terminates the load instead.
- Asynchronous reset mid-session aborts immediately: no further writes, and the CPU stays in reset.

Optional Feature:
- Macro: PROGRAM_LOADER_CHECKSUM_EN.
- When defined:
  - An extra state CHECK follows a halt-word WRITE.
  - The loader waits for one more byte, which must equal the XOR of all data bytes received in the session, including the halt word bytes.
  - Output port o_csum_err (1 bit) is added; it is set to 1 in DONE on mismatch and cleared on i_start or reset.
  - The o_full exit skips CHECK.
  - o_cpu_rst stays 0 when o_csum_err=1.
- When not defined: no CHECK state, no o_csum_err port, and DONE is entered directly after the halt word.

Test Plan:
- Reset, then i_start and bytes 0x08,0x05, 0x00,0x00 -> write 0x0805 @addr 0, then write 0x0000 @addr 1; o_done=1, o_cpu_rst=1, o_full=0.
- Bytes sent with gaps of 0..7 idle cycles, and a byte strobed in the cycle of o_wr_en -> no byte lost; words 0x1234, 0xABCD, 0x0000 written at addrs 0, 1, 2.
- DTBITS=3 build, eight nonzero words 0x1111..0x8888 -> eight writes, addrs 0..7; o_done=1, o_full=1, no ninth write.
- i_rst pulled low after the first byte of a word, then released -> no o_wr_en; outputs at reset values; o_cpu_rst=0; next i_start loads from addr 0.
- i_start pulse during RECV, and i_rx_valid strobes in IDLE/DONE -> no state change and no writes; second i_start in DONE reloads from addr 0 with o_done cleared.
- With PROGRAM_LOADER_CHECKSUM_EN: bytes 0x08,0x05,0x00,0x00, then 0x0D -> o_csum_err=0, o_cpu_rst=1. The same sequence with final byte 0x0C -> o_csum_err=1, o_cpu_rst=0.
